uart_mmio_bridge: RTL and testbench
===================================

Name: uart_mmio_bridge

Overview:
CPU-side endpoint of the UART byte handshake. Exposes a 4-word memory-mapped register window to the core and drives the UART's transmit request and receive-pop handshakes. Holds outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, so software never spins on per-bit timing.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; power of 2, range 2..128
CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived, do not override)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bus_valid  in  1  register access request, accepted in the cycle it is high
bus_we  in  1  1 = write, 0 = read
bus_addr  in  2  word index: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
bus_wdata  in  32  write data
bus_rdata  out  32  read data, registered
bus_ready  out  1  one-cycle response strobe, registered
tx_available  out  1  byte request to UART transmitter
tx_data  out  8  byte to transmit, stable while tx_available=1
tx_ack  in  1  one-cycle pulse, UART has taken tx_data
rx_available  in  1  UART holds a received byte
rx_data  in  8  received byte, valid while rx_available=1
rx_pop  out  1  request to take the held byte
rx_ack  in  1  one-cycle pulse, UART has released the byte
irq  out  1  level interrupt, registered

Behaviour:
- Reset (synchronous, active-high): both FIFOs are emptied and all counters, flags and CTRL bits are cleared. The outputs bus_ready, bus_rdata, tx_available, tx_data, rx_pop and irq are all 0.
- Reset mid-handshake: tx_available and rx_pop drop on the next edge. An in-flight byte is abandoned and no ack is expected after reset.
- Bus timing:
  - Each bus_valid cycle is one access. Side effects occur at that clock edge.
  - bus_ready=1 and bus_rdata appear on the following cycle.
  - Back-to-back accesses are legal.
  - bus_rdata is 0 for writes and for reserved reads.
- DATA write: pushes wdata[7:0] into the TX FIFO if it is not full. If the FIFO is full, the byte is dropped and the sticky flag tx_ovf is set. The full check uses the pre-edge state, so a drain in the same cycle does not rescue the write.
- DATA read:
  - RX FIFO non-empty: returns {23'b0, 1'b1, byte} and pops.
  - RX FIFO empty: returns 0 and does not pop.
- STATUS read layout:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_nonempty
  - [3] tx_ovf
  - [15:8] rx_count
  - [23:16] tx_count
  - All other bits 0.
- STATUS write: a 1 in bit 3 clears tx_ovf. A set and a clear in the same cycle resolves to set.
- CTRL (read/write): [0] ie_rx, [1] ie_tx.
- TX drain FSM, states T_IDLE and T_REQ:
  - T_IDLE: if the TX FIFO is non-empty, drive tx_data from the head, set tx_available=1 and go to T_REQ.
  - T_REQ: hold tx_data and tx_available until tx_ack=1. On that edge pop the head, clear tx_available and return to T_IDLE.
  - Throughput is at most 1 byte per 2 cycles. The head byte is not removed before its ack.
- RX fill FSM, states R_IDLE and R_WAIT:
  - R_IDLE: if rx_available=1 and the RX FIFO is not full, push rx_data, set rx_pop=1 and go to R_WAIT.
  - R_WAIT: hold rx_pop until rx_ack=1, then clear rx_pop and return to R_IDLE.
  - If the RX FIFO is full, no pop is issued and the byte stays in the UART.
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged. Pointers wrap modulo FIFO_DEPTH. Count saturation is impossible by construction.
- RX push and a DATA read of an empty RX FIFO in the same cycle: the read returns 0 and the push still lands.
- irq (registered) = (ie_rx & rx_nonempty) | (ie_tx & tx_empty).

Optional Feature:
UART_MMIO_IRQ_EN
- Defined: the CTRL register and irq behave as described in Behaviour.
- Undefined:
  - CTRL writes are ignored and CTRL reads return 0.
  - irq is tied to 0.
  - No interrupt enable flops are built.

Test Plan:
- Reset, then STATUS read -> rdata=0x00000002 with ready one cycle later; tx_available=0, rx_pop=0, irq=0.
- Write DATA 0x41, then 0x42; UART model acks 3 cycles after each request -> tx_data sequence 0x41, 0x42. tx_available stays high until each ack. STATUS returns to tx_empty.
- With the tx_ack model stalled, write FIFO_DEPTH+1 bytes -> STATUS shows tx_full=1, tx_ovf=1, tx_count=8. Write STATUS 0x8 -> tx_ovf=0. After release, only the first 8 bytes are transmitted.
- Present rx_available with rx_data=0x5A, rx_ack 1 cycle after rx_pop -> exactly one pop. A DATA read returns 0x0000015A; the next DATA read returns 0x00000000.
- Fill the RX FIFO to 8 and present a 9th byte -> rx_pop stays 0 until a DATA read frees a slot, then the byte is accepted.
- With UART_MMIO_IRQ_EN defined, write CTRL=0x1 and deliver a byte -> irq=1; it drops to 0 one cycle after the draining read. With the macro undefined, irq stays 0 and CTRL reads 0.

Source files
------------

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: CPU-side endpoint of the UART byte handshake.
// Four-word register window (DATA, STATUS, CTRL, reserved) in front of a
// TX FIFO drained toward the UART and an RX FIFO filled from the UART.
// Optional feature macro: UART_MMIO_IRQ_EN builds the CTRL interrupt
// enables and the registered irq output; without it CTRL reads 0 and irq is 0.

module uart_mmio_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        tx_available,
  output logic [7:0]  tx_data,
  input  logic        tx_ack,
  input  logic        rx_available,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  input  logic        rx_ack,
  output logic        irq
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]       A_DATA   = 2'd0;
  localparam logic [1:0]       A_STATUS = 2'd1;
  localparam logic [1:0]       A_CTRL   = 2'd2;

  typedef enum logic {T_IDLE, T_REQ}  tx_state_t;
  typedef enum logic {R_IDLE, R_WAIT} rx_state_t;

  tx_state_t tx_state, tx_state_nx;
  rx_state_t rx_state, rx_state_nx;

  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CNT_W-1:0] tx_count, rx_count;

  logic tx_full, tx_empty, rx_full, rx_nonempty, tx_ovf;
  logic data_wr, data_rd, stat_wr;
  logic tx_push, tx_pop_head, tx_load;
  logic rx_push, rx_pop_head;
  logic [31:0] status_word, ctrl_word, rd_word;
  logic unused_wdata;

  assign tx_full     = (tx_count == DEPTH_C);
  assign tx_empty    = (tx_count == '0);
  assign rx_full     = (rx_count == DEPTH_C);
  assign rx_nonempty = (rx_count != '0);

  assign data_wr = bus_valid &  bus_we & (bus_addr == A_DATA);
  assign data_rd = bus_valid & ~bus_we & (bus_addr == A_DATA);
  assign stat_wr = bus_valid &  bus_we & (bus_addr == A_STATUS);

  // Full/empty checks use pre-edge occupancy, so a same-cycle drain never rescues a write.
  assign tx_push     = data_wr & ~tx_full;
  assign rx_pop_head = data_rd & rx_nonempty;

  assign unused_wdata = ^bus_wdata[31:8];

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= bus_wdata[7:0];
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push)     tx_wptr <= tx_wptr + PTR_W'(1);
      if (tx_pop_head) tx_rptr <= tx_rptr + PTR_W'(1);
      case ({tx_push, tx_pop_head})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push)     rx_wptr <= rx_wptr + PTR_W'(1);
      if (rx_pop_head) rx_rptr <= rx_rptr + PTR_W'(1);
      case ({rx_push, rx_pop_head})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky overflow flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
    end else if (data_wr & tx_full) begin
      tx_ovf <= 1'b1;
    end else if (stat_wr & bus_wdata[3]) begin
      tx_ovf <= 1'b0;
    end
  end

  // TX drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_state_nx;
  end

  // TX drain FSM: present the head byte, remove it only once acked
  always_comb begin
    tx_state_nx = tx_state;
    tx_load     = 1'b0;
    tx_pop_head = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty) begin
          tx_load     = 1'b1;
          tx_state_nx = T_REQ;
        end
      end
      T_REQ: begin
        if (tx_ack) begin
          tx_pop_head = 1'b1;
          tx_state_nx = T_IDLE;
        end
      end
      default: tx_state_nx = T_IDLE;
    endcase
  end

  assign tx_available = (tx_state == T_REQ);

  // Byte register toward the UART, loaded when a request starts and held until ack
  always_ff @(posedge clk) begin
    if (rst)          tx_data <= 8'd0;
    else if (tx_load) tx_data <= tx_mem[tx_rptr];
  end

  // RX fill FSM state register
  always_ff @(posedge clk) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_state_nx;
  end

  // RX fill FSM: capture the held byte when there is room, then wait for release
  always_comb begin
    rx_state_nx = rx_state;
    rx_push     = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_available && !rx_full) begin
          rx_push     = 1'b1;
          rx_state_nx = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rx_ack) rx_state_nx = R_IDLE;
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  assign rx_pop = (rx_state == R_WAIT);

  assign status_word = {8'd0, 8'(tx_count), 8'(rx_count), 4'd0,
                        tx_ovf, rx_nonempty, tx_empty, tx_full};

`ifdef UART_MMIO_IRQ_EN
  logic ie_rx, ie_tx;
  logic ctrl_wr;

  assign ctrl_wr   = bus_valid & bus_we & (bus_addr == A_CTRL);
  assign ctrl_word = {30'd0, ie_tx, ie_rx};

  // Interrupt enable register
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
    end else if (ctrl_wr) begin
      ie_rx <= bus_wdata[0];
      ie_tx <= bus_wdata[1];
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (ie_rx & rx_nonempty) | (ie_tx & tx_empty);
  end
`else
  assign ctrl_word = 32'd0;
  assign irq       = 1'b0;
`endif

  // Read data mux; writes and reserved reads return zero
  always_comb begin
    rd_word = 32'd0;
    if (!bus_we) begin
      case (bus_addr)
        A_DATA:   if (rx_nonempty) rd_word = {23'd0, 1'b1, rx_mem[rx_rptr]};
        A_STATUS: rd_word = status_word;
        A_CTRL:   rd_word = ctrl_word;
        default:  rd_word = 32'd0;
      endcase
    end
  end

  // Registered bus response, one cycle after each access
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ready <= 1'b0;
      bus_rdata <= 32'd0;
    end else begin
      bus_ready <= bus_valid;
      bus_rdata <= bus_valid ? rd_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: scoreboard bench for uart_mmio_bridge (FIFO_DEPTH=8).
// Expected bus responses and transmitted bytes are queued when stimulus is
// driven and popped when the DUT answers.

module tb_uart_mmio_bridge;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_valid, bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic        tx_available, tx_ack;
  logic [7:0]  tx_data;
  logic        rx_available, rx_pop, rx_ack;
  logic [7:0]  rx_data;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_send_q[$];

  logic tx_stall = 1'b0;
  int   tx_wait  = 0;
  int   rx_ph    = 0;
  int   rx_acks  = 0;
  int   rx_pop_rises = 0;
  logic rx_pop_prev  = 1'b0;

  uart_mmio_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_valid    (bus_valid),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready),
    .tx_available (tx_available),
    .tx_data      (tx_data),
    .tx_ack       (tx_ack),
    .rx_available (rx_available),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .rx_ack       (rx_ack),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // one access; expected response is queued for the monitor
  task automatic bus_op(input logic we, input logic [1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    exp_q.push_back(exp);
    @(negedge clk);
    check("ready_latency", 32'(bus_ready), 32'd1);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 32'd0;
  endtask

  task automatic write_data(input logic [7:0] b);
    if (tx_exp_q.size() < DEPTH) tx_exp_q.push_back(b);
    bus_op(1'b1, 2'd0, {24'd0, b}, 32'd0);
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 300; i++) begin
      if (tx_exp_q.size() == 0 && !tx_available) break;
      @(negedge clk);
    end
    check("tx_drain", 32'(tx_exp_q.size()), 32'd0);
  endtask

  task automatic wait_rx_acks(input int target);
    for (int i = 0; i < 300; i++) begin
      if (rx_acks >= target) break;
      @(negedge clk);
    end
    check("rx_acks", 32'(rx_acks), 32'(target));
  endtask

  // bus response monitor
  always @(negedge clk) begin
    if (!rst && bus_ready) begin
      if (exp_q.size() == 0) check("bus_spurious", 32'(exp_q.size()), 32'd1);
      else                   check("bus_rdata", bus_rdata, exp_q.pop_front());
    end
  end

  // UART transmitter model: ack 3 cycles after each request unless stalled
  initial begin
    tx_ack = 1'b0;
    forever begin
      @(negedge clk);
      tx_ack = 1'b0;
      if (tx_wait != 0) check("tx_hold", 32'(tx_available), 32'd1);
      if (tx_available && !tx_stall) begin
        tx_wait++;
        if (tx_wait == 3) begin
          tx_ack  = 1'b1;
          tx_wait = 0;
          if (tx_exp_q.size() == 0) check("tx_extra", 32'(tx_data), 32'hFFFF_FFFF);
          else                      check("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
        end
      end
    end
  end

  // UART receiver model: hold a byte until popped, ack one cycle later
  initial begin
    rx_available = 1'b0;
    rx_data      = 8'd0;
    rx_ack       = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_pop && !rx_pop_prev) rx_pop_rises++;
      rx_pop_prev = rx_pop;
      case (rx_ph)
        0: if (rx_send_q.size() > 0) begin
             rx_data      = rx_send_q.pop_front();
             rx_available = 1'b1;
             rx_ph        = 1;
           end
        1: if (rx_pop) begin
             rx_ack       = 1'b1;
             rx_available = 1'b0;
             rx_acks++;
             rx_ph        = 2;
           end
        default: begin
          rx_ack = 1'b0;
          rx_ph  = 0;
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 2'd0;
    bus_wdata = 32'd0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);

    // reset state
    check("rst_ready",  32'(bus_ready), 32'd0);
    check("rst_rdata",  bus_rdata, 32'd0);
    check("rst_tx_av",  32'(tx_available), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rx_pop", 32'(rx_pop), 32'd0);
    check("rst_irq",    32'(irq), 32'd0);
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0002);

    // two bytes through the transmitter
    write_data(8'h41);
    write_data(8'h42);
    wait_tx_drain();
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0002);

    // overflow with stalled transmitter
    tx_stall = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) write_data(8'h10 + 8'(i));
    bus_op(1'b0, 2'd1, 32'd0, 32'h0008_0009);
    bus_op(1'b1, 2'd1, 32'h0000_0008, 32'd0);
    bus_op(1'b0, 2'd1, 32'd0, 32'h0008_0001);
    tx_stall = 1'b0;
    wait_tx_drain();
    wait_cycles(4);
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0002);

    // single received byte
    rx_send_q.push_back(8'h5A);
    wait_rx_acks(1);
    wait_cycles(3);
    check("rx_one_pop", 32'(rx_pop_rises), 32'd1);
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0106);
    bus_op(1'b0, 2'd0, 32'd0, 32'h0000_015A);
    bus_op(1'b0, 2'd0, 32'd0, 32'h0000_0000);

    // RX FIFO full back-pressure
    for (int i = 0; i < DEPTH; i++) rx_send_q.push_back(8'h60 + 8'(i));
    wait_rx_acks(1 + DEPTH);
    wait_cycles(2);
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0806);
    rx_send_q.push_back(8'h68);
    wait_cycles(10);
    check("rx_full_pop", 32'(rx_pop), 32'd0);
    check("rx_full_acks", 32'(rx_acks), 32'(1 + DEPTH));
    bus_op(1'b0, 2'd0, 32'd0, 32'h0000_0160);
    wait_rx_acks(2 + DEPTH);
    for (int i = 1; i <= DEPTH; i++) bus_op(1'b0, 2'd0, 32'd0, 32'h0000_0160 + 32'(i));
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0002);

    // interrupt path
`ifdef UART_MMIO_IRQ_EN
    bus_op(1'b1, 2'd2, 32'h0000_0001, 32'd0);
    bus_op(1'b0, 2'd2, 32'd0, 32'h0000_0001);
    check("irq_idle", 32'(irq), 32'd0);
    rx_send_q.push_back(8'h77);
    wait_rx_acks(3 + DEPTH);
    wait_cycles(2);
    check("irq_set", 32'(irq), 32'd1);
    bus_op(1'b0, 2'd0, 32'd0, 32'h0000_0177);
    wait_cycles(1);
    check("irq_clear", 32'(irq), 32'd0);
    bus_op(1'b1, 2'd2, 32'h0000_0000, 32'd0);
`else
    bus_op(1'b1, 2'd2, 32'h0000_0003, 32'd0);
    bus_op(1'b0, 2'd2, 32'd0, 32'h0000_0000);
    rx_send_q.push_back(8'h77);
    wait_rx_acks(3 + DEPTH);
    wait_cycles(2);
    check("irq_off", 32'(irq), 32'd0);
    bus_op(1'b0, 2'd0, 32'd0, 32'h0000_0177);
`endif

    // reserved address
    bus_op(1'b1, 2'd3, 32'hFFFF_FFFF, 32'd0);
    bus_op(1'b0, 2'd3, 32'd0, 32'd0);

    // reset while a transmit request is outstanding
    tx_stall = 1'b1;
    write_data(8'hAB);
    wait_cycles(2);
    check("mid_tx_av", 32'(tx_available), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_av", 32'(tx_available), 32'd0);
    check("rst_mid_ready", 32'(bus_ready), 32'd0);
    rst = 1'b0;
    tx_exp_q.delete();
    tx_stall = 1'b0;
    wait_cycles(6);
    check("post_rst_tx_av", 32'(tx_available), 32'd0);
    bus_op(1'b0, 2'd1, 32'd0, 32'h0000_0002);

    wait_cycles(4);
    check("bus_pending", 32'(exp_q.size()), 32'd0);
    check("tx_pending", 32'(tx_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
